// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that lets two requesters share
// one sequential sign-magnitude multiplier, with a stop watchdog.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req0/a0/b0           requester 0 request and factors
//   req1/a1/b1           requester 1 request and factors
//   ack0, ack1           grant-cycle pulse, operands captured
//   done, done_id        result-valid pulse and owning requester
//   err                  with done: 1 = watchdog abort
//   result, result_sign  60-bit product magnitude and its sign
//   busy                 high whenever the FSM is not idle
//   mul_start            start strobe to the multiplier
//   mul_operand          shared operand bus (first, then second)
//   mul_out, mul_sign    multiplier product and sign
//   mul_stop             multiplier completion strobe

module mul_arbiter #(
   parameter int unsigned MAX_WAIT = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [30:0] a0,
   input  logic [30:0] b0,
   input  logic        req1,
   input  logic [30:0] a1,
   input  logic [30:0] b1,
   output logic        ack0,
   output logic        ack1,
   output logic        done,
   output logic        done_id,
   output logic        err,
   output logic [59:0] result,
   output logic        result_sign,
   output logic        busy,
   output logic        mul_start,
   output logic [30:0] mul_operand,
   input  logic [59:0] mul_out,
   input  logic        mul_sign,
   input  logic        mul_stop
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD1,
      S_LOAD2,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [3:0] WD_LAST = 4'(MAX_WAIT - 1);

   state_t      state;
   logic [30:0] a_q;
   logic [30:0] b_q;
   logic        id_q;
   logic        rr_last;
   logic [3:0]  wd;
   logic        gnt0;
   logic        gnt1;

   // Grant decode. rr_last is the requester granted most
   // recently; on a tie the other one wins. Gated by rst so
   // no ack escapes while the block is held in reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == S_IDLE && !rst) begin
         unique case (1'b1)
            (req0 && !req1): gnt0 = 1'b1;
            (req1 && !req0): gnt1 = 1'b1;
            (req0 && req1): begin
               gnt0 = rr_last;
               gnt1 = !rr_last;
            end
            default: ;
         endcase
      end
   end

   assign ack0 = gnt0;
   assign ack1 = gnt1;

   // Operand bus follows the state: first factor while the
   // start strobe is high, second factor on the next cycle.
   always_comb begin
      mul_operand = '0;
      unique case (state)
         S_LOAD1: mul_operand = a_q;
         S_LOAD2: mul_operand = b_q;
         default: mul_operand = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         rr_last     <= 1'b1;
         wd          <= '0;
         done        <= 1'b0;
         done_id     <= 1'b0;
         err         <= 1'b0;
         result      <= '0;
         result_sign <= 1'b0;
         busy        <= 1'b0;
         mul_start   <= 1'b0;
      end else begin
         done      <= 1'b0;
         mul_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (gnt0 || gnt1) begin
                  a_q       <= gnt1 ? a1 : a0;
                  b_q       <= gnt1 ? b1 : b0;
                  id_q      <= gnt1;
                  rr_last   <= gnt1;
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_LOAD1;
               end
            end
            S_LOAD1: begin
               state <= S_LOAD2;
            end
            S_LOAD2: begin
               wd    <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (mul_stop) begin
                  result      <= mul_out;
                  result_sign <= mul_sign;
                  err         <= 1'b0;
                  done        <= 1'b1;
                  done_id     <= id_q;
                  state       <= S_DONE;
               end else if (wd == WD_LAST) begin
                  // MAX_WAIT cycles in WAIT with no stop
                  result      <= '0;
                  result_sign <= 1'b0;
                  err         <= 1'b1;
                  done        <= 1'b1;
                  done_id     <= id_q;
                  state       <= S_DONE;
               end else begin
                  wd <= wd + 4'd1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Two-requester controller that shares one sequential multiplier unit.
- The multiplier takes sign-magnitude operands: a 31-bit word, bit 30 is the sign, bits 29:0 are the magnitude. It takes its first operand on the start cycle and its second operand on the following cycle, and raises stop 9 cycles after start.
- This block arbitrates round-robin between the two requesters, latches the granted operands, and sequences the shared operand bus into the multiplier.
- It captures the 60-bit product and sign, returns them with a done pulse, and runs a watchdog against a missing stop.

Parameters:
- MAX_WAIT, 12: number of WAIT cycles without mul_stop before the watchdog aborts. Legal range 9..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0  in  1  requester 0 request
- a0  in  31  requester 0 first factor (sign in bit 30)
- b0  in  31  requester 0 second factor
- req1  in  1  requester 1 request
- a1  in  31  requester 1 first factor
- b1  in  31  requester 1 second factor
- ack0  out  1  one-cycle pulse: requester 0 operands captured
- ack1  out  1  one-cycle pulse: requester 1 operands captured
- done  out  1  one-cycle pulse: result valid
- done_id  out  1  requester that owns the result
- err  out  1  valid with done; 1 means the watchdog aborted
- result  out  60  product magnitude
- result_sign  out  1  product sign
- busy  out  1  high in every state except IDLE
- mul_start  out  1  start strobe to the multiplier
- mul_operand  out  31  shared operand bus, wired to the multiplier's in1 and in2
- mul_out  in  60  multiplier product
- mul_sign  in  1  multiplier sign
- mul_stop  in  1  multiplier completion strobe

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer favours requester 0, watchdog cleared. Reset mid-operation abandons the operation with no done.
- The multiplier has no reset. A stray mul_stop after reset, or mul_stop in any state other than WAIT, is ignored.
- All outputs are registered except mul_operand, which is a combinational mux from the state and the latched operands.
- FSM states: IDLE, LOAD1, LOAD2, WAIT, DONE.
- IDLE:
  - If any req is high, grant one requester and pulse the matching ack in this cycle (combinational from state and req).
  - Latch the granted a and b into internal registers, record the id, then go to LOAD1.
  - If both requesters request, grant the one not granted last. The pointer updates on each grant.
- LOAD1: mul_start=1, mul_operand = latched a, then go to LOAD2.
- LOAD2: mul_start=0, mul_operand = latched b, clear the watchdog, then go to WAIT.
- WAIT and DONE: mul_operand = 0.
- WAIT:
  - If mul_stop=1: register mul_out into result and mul_sign into result_sign, set err=0, go to DONE.
  - Else increment the watchdog. When the count reaches MAX_WAIT, set result=0, result_sign=0, err=1, go to DONE.
- DONE: done=1, done_id = latched id, then go to IDLE. result, result_sign and err hold until the next DONE.
- Timing: grant in cycle g gives mul_start in g+1, second operand in g+2, mul_stop in g+10, and done in g+11. The next grant is possible at g+12, so throughput is one product per 12 cycles.
- Handshake: a requester holds req and its operands until its ack. A req still high in the cycle after its ack counts as a new request. Operands may change freely after ack.
- No arithmetic is done here. Sign-magnitude values pass through unchanged, including a minus-zero product (sign 1, magnitude 0).

Test Plan:
- Single request: req0 with a0=+3 (31'h3), b0=negative 5 (31'h40000005), req0 dropped after ack0.
  - ack0 at g; mul_start at g+1 with mul_operand=31'h3; mul_operand=31'h40000005 at g+2.
  - done at g+11 with result=15, result_sign=1, done_id=0, err=0.
- Simultaneous requests: req0 and req1 held high from reset. ack0 comes first, then ack1 at the IDLE after the first done. Each done_id matches its ack, and the products are correct.
- Back-to-back same requester: req1 held high with constant operands. Grants come every 12 cycles. With req0 also high, grants alternate 1,0,1.
- Watchdog: a bench multiplier model that never raises stop. done arrives MAX_WAIT cycles after entering WAIT with err=1 and result=0, then the block returns to IDLE.
- Stray stop: pulse mul_stop while in IDLE, LOAD1 and LOAD2. No done and no state change.
- Reset mid-WAIT: assert rst at g+6. All outputs are 0 immediately; no done appears for that operation. A fresh req0 after reset completes with a correct result.
